video_timing_gen: RTL and testbench

//   Parametrised raster timing generator for the RGB output path. Scans a

---
 rtl/video_timing_gen_if.sv | 33 +++
 rtl/video_timing_gen.sv | 129 ++++++++++++
 tb/tb_video_timing_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Raster timing bundle: tick enable in, render coordinates and
//               delayed de/hs/vs, frame swap strobe and frame counter out.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int FRAME_CNT_W = 16
);
    logic                   ce;
    logic                   req;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic                   hs;
    logic                   vs;
    logic                   de;
    logic                   swap;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  ce,
        output req, x, y, hs, vs, de, swap, frame_cnt
    );

    modport slave (
        output ce,
        input  req, x, y, hs, vs, de, swap, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing generator; coordinates lead de/hs/vs by
//               LOOKAHEAD ticks to cover renderer latency.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BACK      = 48,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter bit H_POL       = 1'b0,
    parameter int V_ACTIVE    = 480,
    parameter int V_BACK      = 33,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter bit V_POL       = 1'b0,
    parameter int LOOKAHEAD   = 2,
    parameter int SCALE_LOG2  = 0,
    parameter int FRAME_CNT_W = 16
) (
    input  wire logic          clk_rgb,
    input  wire logic          rst,
    video_timing_gen_if.master vid
);
    localparam int c_H_TOTAL = H_BACK + H_ACTIVE + H_FRONT + H_SYNC;
    localparam int c_V_TOTAL = V_BACK + V_ACTIVE + V_FRONT + V_SYNC;
    localparam int c_HCW     = $clog2(c_H_TOTAL);
    localparam int c_VCW     = $clog2(c_V_TOTAL);
    localparam int c_XW      = $clog2(H_ACTIVE >> SCALE_LOG2);
    localparam int c_YW      = $clog2(V_ACTIVE >> SCALE_LOG2);

    localparam logic [c_HCW-1:0] c_H_ACT_START  = c_HCW'(H_BACK);
    localparam logic [c_HCW-1:0] c_H_ACT_END    = c_HCW'(H_BACK + H_ACTIVE);
    localparam logic [c_HCW-1:0] c_H_SYNC_START = c_HCW'(H_BACK + H_ACTIVE + H_FRONT);
    localparam logic [c_HCW-1:0] c_H_LAST       = c_HCW'(c_H_TOTAL - 1);
    localparam logic [c_VCW-1:0] c_V_ACT_START  = c_VCW'(V_BACK);
    localparam logic [c_VCW-1:0] c_V_ACT_END    = c_VCW'(V_BACK + V_ACTIVE);
    localparam logic [c_VCW-1:0] c_V_SYNC_START = c_VCW'(V_BACK + V_ACTIVE + V_FRONT);
    localparam logic [c_VCW-1:0] c_V_LAST       = c_VCW'(c_V_TOTAL - 1);
    localparam logic [2:0]       c_IDLE         = {1'b0, ~H_POL, ~V_POL};

    if ((H_ACTIVE % (1 << SCALE_LOG2)) != 0 || (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_chk_scale
        $error("H_ACTIVE and V_ACTIVE must be multiples of 2**SCALE_LOG2");
    end
    if (c_XW < 1 || c_YW < 1 || c_HCW < 1 || c_VCW < 1 || FRAME_CNT_W < 1) begin : g_chk_width
        $error("derived widths and FRAME_CNT_W must be at least 1");
    end
    if (LOOKAHEAD < 0 || LOOKAHEAD > 15) begin : g_chk_lookahead
        $error("LOOKAHEAD must be in 0..15");
    end

    logic [c_HCW-1:0]       r_hc;
    logic [c_VCW-1:0]       r_vc;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic             w_h_last;
    logic             w_v_last;
    logic             w_swap;
    logic             w_req;
    logic             w_hs0;
    logic             w_vs0;
    logic [c_HCW-1:0] w_hx;
    logic [c_VCW-1:0] w_vy;
    logic [c_HCW-1:0] w_x_full;
    logic [c_VCW-1:0] w_y_full;

    assign w_h_last = (r_hc == c_H_LAST);
    assign w_v_last = (r_vc == c_V_LAST);
    assign w_swap   = vid.ce && w_h_last && w_v_last;

    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            r_hc        <= '0;
            r_vc        <= '0;
            r_frame_cnt <= '0;
        end else if (vid.ce) begin
            if (w_h_last) begin
                r_hc <= '0;
                r_vc <= w_v_last ? '0 : r_vc + c_VCW'(1);
            end else begin
                r_hc <= r_hc + c_HCW'(1);
            end
            if (w_swap) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Stage 0: everything the renderer needs, derived from the live counters
    assign w_req    = (r_hc >= c_H_ACT_START) && (r_hc < c_H_ACT_END) &&
                      (r_vc >= c_V_ACT_START) && (r_vc < c_V_ACT_END);
    assign w_hx     = r_hc - c_H_ACT_START;
    assign w_vy     = r_vc - c_V_ACT_START;
    assign w_x_full = w_hx >> SCALE_LOG2;
    assign w_y_full = w_vy >> SCALE_LOG2;
    assign w_hs0    = (r_hc >= c_H_SYNC_START) ? H_POL : ~H_POL;
    assign w_vs0    = (r_vc >= c_V_SYNC_START) ? V_POL : ~V_POL;

    assign vid.req       = w_req;
    assign vid.x         = w_req ? w_x_full[c_XW-1:0] : '0;
    assign vid.y         = w_req ? w_y_full[c_YW-1:0] : '0;
    assign vid.swap      = w_swap;
    assign vid.frame_cnt = r_frame_cnt;

    if (LOOKAHEAD == 0) begin : g_no_delay
        assign {vid.de, vid.hs, vid.vs} = {w_req, w_hs0, w_vs0};
    end else begin : g_delay
        logic [2:0] r_dly [LOOKAHEAD];

        // Shifts only on ticks so the lag is measured in ticks, not clocks
        always_ff @(posedge clk_rgb) begin
            if (rst) begin
                for (int i = 0; i < LOOKAHEAD; i++) begin
                    r_dly[i] <= c_IDLE;
                end
            end else if (vid.ce) begin
                r_dly[0] <= {w_req, w_hs0, w_vs0};
                for (int i = 1; i < LOOKAHEAD; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end

        assign {vid.de, vid.hs, vid.vs} = r_dly[LOOKAHEAD-1];
    end
endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Two generator configurations against a tick-count raster model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;
    localparam int c_HT    = 13;
    localparam int c_VT    = 7;
    localparam int c_FRAME = c_HT * c_VT;

    logic clk_rgb = 1'b0;
    logic rst     = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_rgb = ~clk_rgb;

    // A: lookahead 3, 2x scaling, 2-bit frame counter, active-low syncs
    video_timing_gen_if #(.XW(2), .YW(1), .FRAME_CNT_W(2)) vif_a ();
    // B: no lookahead, no scaling, 16-bit frame counter, active-high hsync
    video_timing_gen_if #(.XW(3), .YW(2), .FRAME_CNT_W(16)) vif_b ();

    video_timing_gen #(
        .H_ACTIVE(8), .H_BACK(2), .H_FRONT(1), .H_SYNC(2), .H_POL(1'b0),
        .V_ACTIVE(4), .V_BACK(1), .V_FRONT(1), .V_SYNC(1), .V_POL(1'b0),
        .LOOKAHEAD(3), .SCALE_LOG2(1), .FRAME_CNT_W(2)
    ) u_dut_a (
        .clk_rgb (clk_rgb),
        .rst     (rst),
        .vid     (vif_a)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_BACK(2), .H_FRONT(1), .H_SYNC(2), .H_POL(1'b1),
        .V_ACTIVE(4), .V_BACK(1), .V_FRONT(1), .V_SYNC(1), .V_POL(1'b0),
        .LOOKAHEAD(0), .SCALE_LOG2(0), .FRAME_CNT_W(16)
    ) u_dut_b (
        .clk_rgb (clk_rgb),
        .rst     (rst),
        .vid     (vif_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, obs, exp, $time);
        end
    endtask

    // Raster position p (ticks into the frame) mapped to stage-0 values
    task automatic raster(input int p, input int sc, input bit hpol, input bit vpol,
                          output bit rq, output int xx, output int yy,
                          output bit h0, output bit v0);
        int hc, vc;
        hc = p % c_HT;
        vc = p / c_HT;
        rq = (hc >= 2 && hc < 10 && vc >= 1 && vc < 5);
        xx = rq ? ((hc - 2) >> sc) : 0;
        yy = rq ? ((vc - 1) >> sc) : 0;
        h0 = (hc >= 11) ? hpol : ~hpol;
        v0 = (vc >= 6)  ? vpol : ~vpol;
    endtask

    // Expected outputs of one instance given ticks since reset
    task automatic check_inst(input string nm, input int t, input int la, input int sc,
                              input bit hpol, input bit vpol, input int fw, input bit ce_now,
                              input logic o_req, input logic [31:0] o_x, input logic [31:0] o_y,
                              input logic o_de, input logic o_hs, input logic o_vs,
                              input logic o_swap, input logic [31:0] o_fc);
        bit rq, h0, v0, drq, dh, dv;
        int xx, yy, dx, dy;
        raster(t % c_FRAME, sc, hpol, vpol, rq, xx, yy, h0, v0);
        if (t < la) begin
            drq = 1'b0; dh = ~hpol; dv = ~vpol;
        end else begin
            raster((t - la) % c_FRAME, sc, hpol, vpol, drq, dx, dy, dh, dv);
        end
        chk({nm, ".req"},  32'(o_req),  32'(rq));
        chk({nm, ".x"},    o_x,         32'(xx));
        chk({nm, ".y"},    o_y,         32'(yy));
        chk({nm, ".de"},   32'(o_de),   32'(drq));
        chk({nm, ".hs"},   32'(o_hs),   32'(dh));
        chk({nm, ".vs"},   32'(o_vs),   32'(dv));
        chk({nm, ".swap"}, 32'(o_swap), 32'(ce_now && (t % c_FRAME) == c_FRAME - 1));
        chk({nm, ".frame_cnt"}, o_fc, 32'((t / c_FRAME) % (1 << fw)));
    endtask

    initial begin
        int  t;
        bit  did_mid_rst;
        bit  ce_v;
        vif_a.ce = 1'b0;
        vif_b.ce = 1'b0;
        rst = 1'b1;
        t = 0;
        did_mid_rst = 1'b0;
        repeat (2) @(posedge clk_rgb);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_rgb);
            rst = 1'b0;
            if (i < 400)       ce_v = 1'b1;
            else if (i < 1000) ce_v = (i % 2 == 0);
            else               ce_v = ($urandom_range(0, 3) != 0);
            // Mid-frame reset at hc=5, vc=2, plus one at an arbitrary point
            if (i > 1200 && !did_mid_rst && (t % c_FRAME) == 2 * c_HT + 5) begin
                rst = 1'b1;
                did_mid_rst = 1'b1;
            end
            if (i == 2500) rst = 1'b1;
            vif_a.ce = ce_v;
            vif_b.ce = ce_v;
            #1;
            check_inst("A", t, 3, 1, 1'b0, 1'b0, 2, ce_v,
                       vif_a.req, 32'(vif_a.x), 32'(vif_a.y), vif_a.de, vif_a.hs, vif_a.vs,
                       vif_a.swap, 32'(vif_a.frame_cnt));
            check_inst("B", t, 0, 0, 1'b1, 1'b0, 16, ce_v,
                       vif_b.req, 32'(vif_b.x), 32'(vif_b.y), vif_b.de, vif_b.hs, vif_b.vs,
                       vif_b.swap, 32'(vif_b.frame_cnt));
            if (rst)       t = 0;
            else if (ce_v) t++;
        end
        if (!did_mid_rst) chk("mid_frame_reset_reached", 32'(did_mid_rst), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
